line_window_gen: RTL and testbench

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

---
 rtl/line_window_gen.sv | 159 +++++++++++++++
 tb/tb_line_window_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : line_window_gen
// Purpose  : Streams raster-order pixels and produces a registered KxK
//            neighbourhood window per accepted pixel. Line storage holds the
//            K-1 previous lines; a KxK shift register holds the window.
//            Valid_OUT marks windows that lie fully inside the current frame.
// Revision : 1.0 - initial release
// ============================================================================
module line_window_gen #(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = 8,
  parameter int K          = 5
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic [Datawidth-1:0]       In,
  input  logic                       Valid_IN,
  input  logic                       SOF,
  output logic [K*K*Datawidth-1:0]   Window,
  output logic                       Valid_OUT,
  output logic                       EOF_OUT
);

  // Illegal geometry is caught while the design is being elaborated.
  generate
    if ((K % 2 == 0) || (K < 3) || (K > 7) ||
        (IMG_Width < K) || (IMG_Height < K)) begin : g_param_check
      $error("line_window_gen: K must be odd in 3..7 and not exceed the image size");
    end
  endgenerate

  localparam int XW = $clog2(IMG_Width);
  localparam int YW = $clog2(IMG_Height);
  localparam int NL = K - 1;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_Width - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_Height - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);

  // Position of the next pixel to be accepted.
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // Position of the pixel on the inputs this cycle (SOF forces the origin).
  logic [XW-1:0] x_cur;
  logic [YW-1:0] y_cur;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  logic win_ok;
  logic frame_last;

  // Line storage: line_mem[0] is the previous line, line_mem[NL-1] the oldest.
  logic [Datawidth-1:0] line_mem [NL][IMG_Width];

  // Column entering the window: col[0] oldest line, col[K-1] the live pixel.
  logic [Datawidth-1:0] col [K];

  logic [K*K*Datawidth-1:0] window_q;
  logic                     valid_q;
  logic                     eof_q;

  // Resolve the current pixel position, honouring SOF only when qualified.
  always_comb begin
    x_cur = x_cnt;
    y_cur = y_cnt;
    if (Valid_IN && SOF) begin
      x_cur = '0;
      y_cur = '0;
    end
  end

  // Raster advance with wrap at end of line and end of frame.
  always_comb begin
    x_nxt = x_cur + XW'(1);
    y_nxt = y_cur;
    if (x_cur == X_LAST) begin
      x_nxt = '0;
      if (y_cur == Y_LAST) begin
        y_nxt = '0;
      end else begin
        y_nxt = y_cur + YW'(1);
      end
    end
  end

  // Window qualification: a full KxK neighbourhood exists inside this frame.
  always_comb begin
    win_ok     = (x_cur >= X_FIRST) && (y_cur >= Y_FIRST);
    frame_last = (x_cur == X_LAST) && (y_cur == Y_LAST);
  end

  // Gather the vertical column at x_cur from line storage plus the live pixel.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      col[r] = In;
    end
    for (int r = 0; r < K - 1; r++) begin
      col[r] = line_mem[K-2-r][x_cur];
    end
  end

  // Column/row counters; cleared by reset and held while no pixel is offered.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (Valid_IN) begin
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  // Line storage shifts one line deeper at the current column; stale content
  // after reset or SOF is never exposed because win_ok gates Valid_OUT.
  always_ff @(posedge CLK) begin
    if (Valid_IN) begin
      line_mem[0][x_cur] <= In;
      for (int j = 1; j < NL; j++) begin
        line_mem[j][x_cur] <= line_mem[j-1][x_cur];
      end
    end
  end

  // Window shift register: columns move toward c=0, new column enters at c=K-1.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      window_q <= '0;
    end else if (Valid_IN) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          window_q[(r*K+c)*Datawidth +: Datawidth] <=
            window_q[(r*K+c+1)*Datawidth +: Datawidth];
        end
        window_q[(r*K+K-1)*Datawidth +: Datawidth] <= col[r];
      end
    end
  end

  // Output flags are single-cycle pulses tied to an accepted pixel.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      valid_q <= Valid_IN && win_ok;
      eof_q   <= Valid_IN && win_ok && frame_last;
    end
  end

  assign Window    = window_q;
  assign Valid_OUT = valid_q;
  assign EOF_OUT   = eof_q;

endmodule
`default_nettype wire

// File: tb/tb_line_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window_gen
// Purpose  : Directed self-checking bench for line_window_gen: a default
//            8x8/K=5 instance and a 6x4/K=3 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [7:0]   pix;
  logic         vin;
  logic         sof;
  logic [199:0] win;
  logic         vout;
  logic         eof;

  logic [7:0]   pix3;
  logic         vin3;
  logic         sof3;
  logic [71:0]  win3;
  logic         vout3;
  logic         eof3;

  line_window_gen #(.IMG_Width(8), .IMG_Height(8), .Datawidth(8), .K(5)) dut (
    .CLK(clk), .CLR(rst_n), .In(pix), .Valid_IN(vin), .SOF(sof),
    .Window(win), .Valid_OUT(vout), .EOF_OUT(eof)
  );

  line_window_gen #(.IMG_Width(6), .IMG_Height(4), .Datawidth(8), .K(3)) dut3 (
    .CLK(clk), .CLR(rst_n), .In(pix3), .Valid_IN(vin3), .SOF(sof3),
    .Window(win3), .Valid_OUT(vout3), .EOF_OUT(eof3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int idx;
    bit valid;
    bit eofx;
    int e00;
    int e22;
    int e44;
  } vec_t;

  vec_t tbl [8];

  task automatic check(string name, logic [199:0] act, logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected 5x5 window for pixel (x,y) of a frame where P(x,y)=y*8+x+off.
  function automatic logic [199:0] exp5(int x, int y, int off);
    logic [199:0] v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        v[(r*5+c)*8 +: 8] = 8'(((y-4+r)*8 + (x-4+c) + off) % 256);
    return v;
  endfunction

  // Expected 3x3 window for the 6x4 instance where P(x,y)=(y*6+x)*3+1.
  function automatic logic [71:0] exp3(int x, int y);
    logic [71:0] v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*8 +: 8] = 8'(((y-2+r)*6 + (x-2+c)) * 3 + 1);
    return v;
  endfunction

  task automatic step(bit v, bit s, logic [7:0] d);
    vin = v; sof = s; pix = d;
    @(posedge clk); #1;
  endtask

  task automatic stream(int n, int off);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'(((i/8)*8 + (i%8) + off) % 256));
    vin = 1'b0; sof = 1'b0;
  endtask

  task automatic run_frame(int off, bit use_sof, bit gaps, string tag);
    int nv = 0;
    int ne = 0;
    logic [199:0] last_exp = '0;
    for (int i = 0; i < 64; i++) begin
      int x = i % 8;
      int y = i / 8;
      bit ev = (x >= 4) && (y >= 4);
      bit ee = (i == 63);
      step(1'b1, use_sof && (i == 0), 8'((y*8 + x + off) % 256));
      check($sformatf("%s valid@%0d", tag, i), 200'(vout), 200'(ev));
      check($sformatf("%s eof@%0d", tag, i), 200'(eof), 200'(ee));
      if (vout) nv++;
      if (eof) ne++;
      if (ev) begin
        last_exp = exp5(x, y, off);
        check($sformatf("%s window@%0d", tag, i), win, last_exp);
      end
      for (int t = 0; t < 8; t++) begin
        if (tbl[t].idx == i) begin
          check($sformatf("%s tbl valid@%0d", tag, i), 200'(vout), 200'(tbl[t].valid));
          check($sformatf("%s tbl eof@%0d", tag, i), 200'(eof), 200'(tbl[t].eofx));
          if (tbl[t].valid) begin
            check($sformatf("%s tbl e00@%0d", tag, i), 200'(win[7:0]),     200'((tbl[t].e00 + off) % 256));
            check($sformatf("%s tbl e22@%0d", tag, i), 200'(win[103:96]),  200'((tbl[t].e22 + off) % 256));
            check($sformatf("%s tbl e44@%0d", tag, i), 200'(win[199:192]), 200'((tbl[t].e44 + off) % 256));
          end
        end
      end
      if (gaps) begin
        // Idle cycle, with SOF toggled on to confirm it is ignored unqualified.
        step(1'b0, (i % 2) == 0, 8'hA5);
        check($sformatf("%s gap valid@%0d", tag, i), 200'(vout), 200'(0));
        check($sformatf("%s gap eof@%0d", tag, i), 200'(eof), 200'(0));
        if (ev) check($sformatf("%s gap frozen@%0d", tag, i), win, last_exp);
      end
    end
    vin = 1'b0; sof = 1'b0;
    check($sformatf("%s valid count", tag), 200'(nv), 200'(16));
    check($sformatf("%s eof count", tag), 200'(ne), 200'(1));
  endtask

  task automatic run_frame3(bit use_sof, string tag);
    int nv = 0;
    for (int i = 0; i < 24; i++) begin
      int x = i % 6;
      int y = i / 6;
      bit ev = (x >= 2) && (y >= 2);
      vin3 = 1'b1; sof3 = use_sof && (i == 0); pix3 = 8'((y*6 + x) * 3 + 1);
      @(posedge clk); #1;
      check($sformatf("%s valid@%0d", tag, i), 200'(vout3), 200'(ev));
      check($sformatf("%s eof@%0d", tag, i), 200'(eof3), 200'(i == 23));
      if (vout3) nv++;
      if (ev) check($sformatf("%s window@%0d", tag, i), 200'(win3), 200'(exp3(x, y)));
      if (i == 14) check($sformatf("%s first e00", tag), 200'(win3[7:0]), 200'(1));
    end
    vin3 = 1'b0; sof3 = 1'b0;
    check($sformatf("%s valid count", tag), 200'(nv), 200'(8));
  endtask

  initial begin
    tbl[0] = '{idx: 35, valid: 1'b0, eofx: 1'b0, e00: 0,  e22: 0,  e44: 0};
    tbl[1] = '{idx: 36, valid: 1'b1, eofx: 1'b0, e00: 0,  e22: 18, e44: 36};
    tbl[2] = '{idx: 37, valid: 1'b1, eofx: 1'b0, e00: 1,  e22: 19, e44: 37};
    tbl[3] = '{idx: 39, valid: 1'b1, eofx: 1'b0, e00: 3,  e22: 21, e44: 39};
    tbl[4] = '{idx: 40, valid: 1'b0, eofx: 1'b0, e00: 0,  e22: 0,  e44: 0};
    tbl[5] = '{idx: 44, valid: 1'b1, eofx: 1'b0, e00: 8,  e22: 26, e44: 44};
    tbl[6] = '{idx: 62, valid: 1'b1, eofx: 1'b0, e00: 26, e22: 44, e44: 62};
    tbl[7] = '{idx: 63, valid: 1'b1, eofx: 1'b1, e00: 27, e22: 45, e44: 63};

    rst_n = 1'b1; vin = 1'b0; sof = 1'b0; pix = '0;
    vin3 = 1'b0; sof3 = 1'b0; pix3 = '0;

    // Reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset window", win, '0);
    check("reset valid", 200'(vout), 200'(0));
    check("reset eof", 200'(eof), 200'(0));
    check("reset window3", 200'(win3), 200'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0,   1'b0, 1'b0, "f1");
    run_frame(50,  1'b1, 1'b1, "gap");
    run_frame(100, 1'b1, 1'b0, "b2b_a");
    run_frame(150, 1'b1, 1'b0, "b2b_b");

    // SOF arriving at pixel 20 of a running frame restarts at the origin.
    stream(20, 200);
    run_frame(20, 1'b1, 1'b0, "sof20");

    // Asynchronous reset between clock edges after pixel 39 of a frame.
    stream(40, 7);
    check("pre-reset valid", 200'(vout), 200'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midreset window", win, '0);
    check("midreset valid", 200'(vout), 200'(0));
    check("midreset eof", 200'(eof), 200'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(30, 1'b0, 1'b0, "post_rst");

    run_frame3(1'b0, "k3_a");
    run_frame3(1'b1, "k3_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
